// File: rtl/window_gen_3x3_pkg.sv
// Shared constants and helpers for the 3x3 window generator.
package window_gen_3x3_pkg;

    // Default pixel width in bits.
    localparam int PIX_W_DEFAULT = 8;

    // Bits needed to count 0..bound-1; never less than one bit.
    function automatic int cnt_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in, 3x3 window out. The producer of pixels is the master;
// the window generator is the slave.
interface window_gen_3x3_if
    import window_gen_3x3_pkg::*;
#(
    parameter int n = PIX_W_DEFAULT
) ();

    logic [n-1:0] pix_in;
    logic         pix_valid;
    logic         sof;
    logic [n-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic         win_valid;
    logic         frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, frame_done
    );

endinterface

// File: rtl/window_gen_3x3_line_buf.sv
// One image line of storage. Read is combinational and returns the old
// word, so a write to the same address in the same cycle is read-before-write.
module line_buf
    import window_gen_3x3_pkg::*;
#(
    parameter int n     = PIX_W_DEFAULT,
    parameter int DEPTH = 640,
    localparam int AW   = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [n-1:0]  din,
    output logic [n-1:0]  dout
);

    logic [n-1:0] mem [0:DEPTH-1];

    assign dout = mem[addr];

    // Store the incoming word; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator. Two line buffers hold rows r-1 and
// r-2; three column shift registers present the window of the most recently
// accepted pixel. Only fully interior windows are flagged valid.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int n     = PIX_W_DEFAULT,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             reset,
    window_gen_3x3_if.slave  bus
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    logic [COL_W-1:0] col_reg, col_next, cur_col;
    logic [ROW_W-1:0] row_reg, row_next, cur_row;
    logic             win_valid_reg, win_valid_next;
    logic             frame_done_reg, frame_done_next;
    logic             take_sof;
    logic [n-1:0]     lb0_rd, lb1_rd;
    logic [n-1:0]     col_in [0:2];

    // A qualified sof forces the current pixel to (0,0).
    assign take_sof = bus.pix_valid & bus.sof;

    // Position of the pixel on the bus and counter/strobe updates it implies.
    always_comb begin
        cur_col         = take_sof ? '0 : col_reg;
        cur_row         = take_sof ? '0 : row_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        frame_done_next = 1'b0;
        win_valid_next  = 1'b0;
        if (bus.pix_valid) begin
            win_valid_next = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_next = '0;
                if (cur_row == ROW_W'(IMG_H - 1)) begin
                    row_next        = '0;
                    frame_done_next = 1'b1;
                end else begin
                    row_next = cur_row + ROW_W'(1);
                end
            end else begin
                col_next = cur_col + COL_W'(1);
                row_next = cur_row;
            end
        end
    end

    // Raster position and the one-cycle output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            win_valid_reg  <= win_valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // lb0 holds row r-1; lb1 takes lb0's displaced word and so holds row r-2.
    line_buf #(.n(n), .DEPTH(IMG_W)) lb0 (
        .clk   (clk),
        .wr_en (bus.pix_valid),
        .addr  (cur_col),
        .din   (bus.pix_in),
        .dout  (lb0_rd)
    );

    line_buf #(.n(n), .DEPTH(IMG_W)) lb1 (
        .clk   (clk),
        .wr_en (bus.pix_valid),
        .addr  (cur_col),
        .din   (lb0_rd),
        .dout  (lb1_rd)
    );

    // New right-hand column, top to bottom.
    assign col_in[0] = lb1_rd;
    assign col_in[1] = lb0_rd;
    assign col_in[2] = bus.pix_in;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : row_g
            logic [n-1:0] tap [0:2];

            // Shift this window row left and load the new right pixel.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tap[0] <= '0;
                    tap[1] <= '0;
                    tap[2] <= '0;
                end else if (bus.pix_valid) begin
                    tap[0] <= tap[1];
                    tap[1] <= tap[2];
                    tap[2] <= col_in[gi];
                end
            end
        end
    endgenerate

    assign bus.w1 = row_g[0].tap[0];
    assign bus.w2 = row_g[0].tap[1];
    assign bus.w3 = row_g[0].tap[2];
    assign bus.w4 = row_g[1].tap[0];
    assign bus.w5 = row_g[1].tap[1];
    assign bus.w6 = row_g[1].tap[2];
    assign bus.w7 = row_g[2].tap[0];
    assign bus.w8 = row_g[2].tap[1];
    assign bus.w9 = row_g[2].tap[2];

    assign bus.win_valid  = win_valid_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
